// File: rtl/branch_sequencer.sv
// Execute-stage conditional branch sequencer: operand wait, evaluation, redirect.
// Optional BRANCH_STATS_EN adds resolved/mispredict counters.
module branch_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] issue_pc,
    input  logic [12:0]           issue_imm,
    input  logic [2:0]            issue_funct3,
    input  logic                  issue_pred_taken,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  rs1_valid,
    input  logic                  rs2_valid,
    input  logic                  flush,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  resolve_valid,
    output logic                  resolve_taken,
    output logic                  resolve_mispredict,
    output logic                  exc_illegal,
    output logic                  exc_misaligned,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPS,
        REDIRECT
    } state_t;

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [12:0]           imm_q;
    logic [2:0]            f3_q;
    logic                  pred_q;

    logic [ADDR_WIDTH-1:0] target, fall;
    logic                  cond, illegal;
    logic                  res_nx, ill_nx, mis_nx, latch_rpc;

    assign target = pc_q + {{(ADDR_WIDTH-13){imm_q[12]}}, imm_q};
    assign fall   = pc_q + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

    assign issue_ready = (state == IDLE);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (f3_q)
            3'd0:    cond = (rs1_data == rs2_data);
            3'd1:    cond = (rs1_data != rs2_data);
            3'd4:    cond = ($signed(rs1_data) < $signed(rs2_data));
            3'd5:    cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'd6:    cond = (rs1_data < rs2_data);
            3'd7:    cond = (rs1_data >= rs2_data);
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_nx  = state;
        res_nx    = 1'b0;
        ill_nx    = 1'b0;
        mis_nx    = 1'b0;
        latch_rpc = 1'b0;
        case (state)
            IDLE: begin
                if (issue_valid) state_nx = WAIT_OPS;
            end
            WAIT_OPS: begin
                if (rs1_valid && rs2_valid) begin
                    state_nx = IDLE;
                    if (illegal) begin
                        ill_nx = 1'b1;
                    end else if (cond && target[1:0] != 2'b00) begin
                        mis_nx = 1'b1;
                    end else begin
                        res_nx = 1'b1;
                        if (cond != pred_q) begin
                            latch_rpc = 1'b1;
                            state_nx  = REDIRECT;
                        end
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // A kill overrides every transition and every event of this cycle.
        if (flush) begin
            state_nx  = IDLE;
            res_nx    = 1'b0;
            ill_nx    = 1'b0;
            mis_nx    = 1'b0;
            latch_rpc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc_q   <= '0;
            imm_q  <= '0;
            f3_q   <= '0;
            pred_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && issue_valid && !flush) begin
                pc_q   <= issue_pc;
                imm_q  <= issue_imm;
                f3_q   <= issue_funct3;
                pred_q <= issue_pred_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolve_valid      <= 1'b0;
            resolve_taken      <= 1'b0;
            resolve_mispredict <= 1'b0;
            exc_illegal        <= 1'b0;
            exc_misaligned     <= 1'b0;
            redirect_valid     <= 1'b0;
            redirect_pc        <= '0;
        end else begin
            resolve_valid      <= res_nx;
            resolve_taken      <= res_nx & cond;
            resolve_mispredict <= res_nx & (cond != pred_q);
            exc_illegal        <= ill_nx;
            exc_misaligned     <= mis_nx;
            redirect_valid     <= (state_nx == REDIRECT);
            if (latch_rpc) redirect_pc <= cond ? target : fall;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (resolve_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (resolve_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed plan plus random branches
// compared against a behavioural outcome model.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_pc;
    logic [12:0] issue_imm;
    logic [2:0]  issue_funct3;
    logic        issue_pred_taken;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_valid, rs2_valid;
    logic        flush;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        resolve_valid, resolve_taken, resolve_mispredict;
    logic        exc_illegal, exc_misaligned;
    logic [31:0] stat_branches, stat_mispredicts;

    int total = 0;
    int bad   = 0;
    int exp_br = 0;
    int exp_mp = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_funct3(issue_funct3), .issue_pred_taken(issue_pred_taken),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
        .flush(flush),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_mispredict(resolve_mispredict),
        .exc_illegal(exc_illegal), .exc_misaligned(exc_misaligned),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 illegal, 1 misaligned, 2 resolved
    function automatic void model(
        input  logic [31:0] pc, input logic [12:0] imm, input logic [2:0] f3,
        input  logic pred, input logic [31:0] a, input logic [31:0] b,
        output int kind, output bit taken, output bit mp, output logic [31:0] rpc);
        longint sa, sb, ua, ub, t;
        logic [31:0] tgt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        t  = longint'({32'd0, pc}) + longint'($signed(imm));
        tgt = t[31:0];
        taken = 0;
        kind = 2;
        case (f3)
            3'd0: taken = (ua == ub);
            3'd1: taken = (ua != ub);
            3'd4: taken = (sa < sb);
            3'd5: taken = !(sa < sb);
            3'd6: taken = (ua < ub);
            3'd7: taken = !(ua < ub);
            default: kind = 0;
        endcase
        if (kind == 2 && taken && (tgt % 4) != 0) kind = 1;
        mp  = (kind == 2) && (taken != pred);
        rpc = taken ? tgt : pc + 32'd4;
    endfunction

    task automatic run_branch(
        input logic [31:0] pc, input logic [12:0] imm, input logic [2:0] f3,
        input logic pred, input logic [31:0] a, input logic [31:0] b,
        input int wait_cyc, input int hold_cyc);
        int kind;
        bit taken, mp;
        logic [31:0] rpc;
        model(pc, imm, f3, pred, a, b, kind, taken, mp, rpc);
        @(negedge clk);
        chk("issue_ready_idle", issue_ready, 1);
        issue_valid = 1; issue_pc = pc; issue_imm = imm;
        issue_funct3 = f3; issue_pred_taken = pred;
        rs1_data = a; rs2_data = b; rs1_valid = 1; rs2_valid = (wait_cyc == 0);
        @(posedge clk);
        @(negedge clk);
        issue_valid = 0;
        chk("issue_ready_busy", issue_ready, 0);
        for (int i = 0; i < wait_cyc; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_resolve_wait", resolve_valid, 0);
            chk("no_exc_wait", exc_illegal | exc_misaligned, 0);
        end
        rs2_valid = 1;
        @(posedge clk);
        @(negedge clk);
        rs1_valid = 0; rs2_valid = 0;
        chk("resolve_valid", resolve_valid, kind == 2);
        chk("exc_illegal", exc_illegal, kind == 0);
        chk("exc_misaligned", exc_misaligned, kind == 1);
        chk("redirect_valid", redirect_valid, mp);
        if (kind == 2) begin
            chk("resolve_taken", resolve_taken, taken);
            chk("resolve_mispredict", resolve_mispredict, mp);
            exp_br++;
            if (mp) exp_mp++;
        end
        if (mp) begin
            chk("redirect_pc", redirect_pc, rpc);
            for (int i = 0; i < hold_cyc; i++) begin
                @(posedge clk);
                @(negedge clk);
                chk("redirect_hold_valid", redirect_valid, 1);
                chk("redirect_hold_pc", redirect_pc, rpc);
                chk("resolve_pulse_once", resolve_valid, 0);
            end
            redirect_ready = 1;
            @(posedge clk);
            @(negedge clk);
            redirect_ready = 0;
            chk("redirect_done", redirect_valid, 0);
            chk("ready_after_redirect", issue_ready, 1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            chk("pulse_drop", resolve_valid | exc_illegal | exc_misaligned, 0);
        end
    endtask

    // Enter REDIRECT with a guaranteed mispredict (BEQ equal, predicted not taken).
    task automatic to_redirect(input logic [31:0] pc);
        @(negedge clk);
        issue_valid = 1; issue_pc = pc; issue_imm = 13'h010;
        issue_funct3 = 3'd0; issue_pred_taken = 0;
        rs1_data = 7; rs2_data = 7; rs1_valid = 1; rs2_valid = 1;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rs1_valid = 0; rs2_valid = 0;
        exp_br++; exp_mp++;
        chk("enter_redirect", redirect_valid, 1);
    endtask

    initial begin
        logic [2:0] f3;
        logic [12:0] imm;
        logic [31:0] a, b;
        rst_n = 0;
        issue_valid = 0; issue_pc = 0; issue_imm = 0; issue_funct3 = 0;
        issue_pred_taken = 0; rs1_data = 0; rs2_data = 0;
        rs1_valid = 0; rs2_valid = 0; flush = 0; redirect_ready = 0;
        #12;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_resolve", resolve_valid | resolve_taken | resolve_mispredict, 0);
        chk("rst_exc", exc_illegal | exc_misaligned, 0);
        chk("rst_stats", stat_branches | stat_mispredicts, 0);
        rst_n = 1;

        run_branch(32'h100, 13'h010, 3'd0, 0, 5, 5, 0, 3);
        run_branch(32'h200, 13'h020, 3'd4, 1, 32'hFFFFFFFF, 1, 0, 0);
        run_branch(32'h200, 13'h020, 3'd6, 1, 32'hFFFFFFFF, 1, 0, 1);
        run_branch(32'h300, 13'h1FF8, 3'd1, 1, 3, 4, 4, 0);
        run_branch(32'h400, 13'h008, 3'd2, 0, 1, 1, 0, 0);
        run_branch(32'h400, 13'h008, 3'd3, 1, 1, 2, 0, 0);
        run_branch(32'h500, 13'h002, 3'd0, 1, 9, 9, 0, 0);
        run_branch(32'hFFFFFFFC, 13'h008, 3'd7, 0, 8, 8, 0, 0);
        run_branch(32'hFFFFFFFC, 13'h008, 3'd5, 1, 1, 2, 1, 0);

        // flush while waiting for operands
        @(negedge clk);
        issue_valid = 1; issue_pc = 32'h600; issue_imm = 13'h010;
        issue_funct3 = 3'd0; issue_pred_taken = 0;
        rs1_data = 1; rs2_data = 1; rs1_valid = 0; rs2_valid = 0;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 0; rs1_valid = 1; rs2_valid = 1; flush = 1;
        @(posedge clk);
        @(negedge clk);
        flush = 0; rs1_valid = 0; rs2_valid = 0;
        chk("flush_wait_ready", issue_ready, 1);
        chk("flush_wait_resolve", resolve_valid, 0);
        chk("flush_wait_redirect", redirect_valid, 0);

        // flush while redirecting
        to_redirect(32'h700);
        flush = 1;
        @(posedge clk);
        @(negedge clk);
        flush = 0;
        chk("flush_redir_valid", redirect_valid, 0);
        chk("flush_redir_ready", issue_ready, 1);

        // issue handshake coinciding with flush is discarded
        @(negedge clk);
        issue_valid = 1; flush = 1;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 0; flush = 0;
        chk("flush_issue_dropped", issue_ready, 1);

        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            if ((f3 == 3'd2 || f3 == 3'd3) && $urandom_range(0, 2) != 0) f3 = 3'd4;
            imm = 13'($urandom) & 13'h1FFE;
            if ($urandom_range(0, 3) != 0) imm = imm & 13'h1FFC;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_branch($urandom & 32'hFFFFFFFC, imm, f3, 1'($urandom),
                       a, b, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        @(negedge clk);
        @(negedge clk);
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, exp_br);
        chk("stat_mispredicts", stat_mispredicts, exp_mp);
`else
        chk("stat_branches_off", stat_branches, 0);
        chk("stat_mispredicts_off", stat_mispredicts, 0);
`endif

        // asynchronous reset in the middle of a redirect
        to_redirect(32'h800);
        #1 rst_n = 0;
        #1;
        chk("arst_redirect_valid", redirect_valid, 0);
        chk("arst_issue_ready", issue_ready, 1);
        chk("arst_stats", stat_branches | stat_mispredicts, 0);
        @(negedge clk);
        rst_n = 1;
        run_branch(32'h900, 13'h004, 3'd1, 1, 1, 2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
